uart_msg_parser: RTL and testbench
==================================

// Module: uart_msg_parser
// PURPOSE
//  Receive-side counterpart of the UART message sender. Consumes bytes from the UART RX
//  (rx_byte qualified by rx_data_valid) and parses frames "SI-SIM<d>-<L>-#"<0x0D>.
//  Outputs the decoded SIM number, unit letter and one-hot colour code, pulsing msg_valid on a good frame
//  and msg_error on a malformed or timed-out frame. Sits between uart_rx and the control logic.
// PARAMETERS
//  TIMEOUT_CYCLES  50_000_000  max clk cycles between bytes inside a frame before abort (1 s @ 50 MHz)
//  CNT_W           26          width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  rst_n          in   1  synchronous reset, active-low
//  rx_data_valid  in   1  1-cycle strobe: rx_byte holds a new received byte
//  rx_byte        in   8  received byte
//  msg_valid      out  1  1-cycle pulse: complete valid frame parsed
//  msg_error      out  1  1-cycle pulse: frame aborted (mismatch or timeout)
//  sim_id         out  4  binary SIM number 0-9, from last valid frame
//  unit_code      out  8  ASCII unit letter, from last valid frame
//  color_out      out  3  one-hot colour: 001 red (P), 010 blue (W), 100 green (N), 000 other
//  busy           out  1  high while a frame is partially received
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, idx=0, timer=0; all outputs 0. Reset mid-frame discards it, no error pulse.
//  - Template by idx 0..11: 'S','I','-','S','I','M',DIGIT,'-',LETTER,'-','#',8'h0D.
//    DIGIT = '0'..'9'; LETTER = 'A'..'Z'. Any other byte at those slots is a mismatch.
//  - States: IDLE -> RECV -> IDLE. Bytes are only examined on cycles with rx_data_valid=1.
//  - IDLE: byte=='S' -> RECV, idx=1, timer=0. Other bytes ignored silently (no error).
//  - RECV, matching byte at idx<11: idx<=idx+1, timer=0, capture DIGIT/LETTER into shadow regs.
//  - RECV, idx==11 and byte==0x0D: next cycle msg_valid=1 for exactly 1 cycle, and sim_id/unit_code/
//    color_out update from shadow regs in that same cycle; return IDLE. Latency: 1 clk after terminator strobe.
//  - RECV, mismatch: msg_error=1 for 1 cycle next clk; if the offending byte is 'S' go RECV with idx=1
//    (resync), else IDLE. sim_id/unit_code/color_out keep previous values.
//  - Timeout: in RECV, timer increments on every cycle without rx_data_valid; when timer reaches
//    TIMEOUT_CYCLES-1 -> msg_error pulse, IDLE. A strobe arriving in the expiry cycle takes priority
//    (processed normally, timer cleared).
//  - msg_valid and msg_error never high together. busy = (state==RECV).
//  - Colour map: 'P'->3'b001, 'W'->3'b010, 'N'->3'b100; other letters give 3'b000 but frame still valid.
//  - Back-to-back frames with no gap between terminator and next 'S' are accepted.
// CONFIGURATION
//  UART_PARSER_LED_EN defined: adds outputs led_R, led_G, led_B (1 bit each), reset 0, driven
//    from color_out bits [0],[2],[1] respectively; updated only with msg_valid.
//  Not defined: LED ports and logic absent; all other behaviour identical.
// TESTING
//  - Send "SI-SIM1-P-#",0x0D with 10-clk gaps -> one msg_valid pulse; sim_id=1, unit_code=8'h50, color_out=001.
//  - Send "SI-SIM3-W-#",0x0D then immediately "SI-SIM2-N-#",0x0D -> two pulses; final sim_id=2, color_out=100.
//  - Send "SI-SIX"... -> msg_error pulse on 'X'; outputs unchanged; busy drops to 0.
//  - Send "SI-SI","S","I-SIM4-P-#",0x0D (i.e. 'S' at mismatch slot) -> one msg_error, then msg_valid with sim_id=4.
//  - TIMEOUT_CYCLES=100: send "SI-S" then idle 100 clks -> msg_error exactly once; busy=0 afterwards.
//  - Assert rst_n=0 after "SI-SIM5" then full frame "SI-SIM6-N-#",0x0D -> no error pulse; sim_id=6, color_out=100.

Source files
------------

// File: rtl/uart_msg_parser_if.sv
// Bus between uart_rx, the message parser and the control logic.
// slave: parser side (consumes RX bytes, produces decoded message).
// master: environment side (drives RX bytes, observes decoded message).
interface uart_msg_parser_if;
  logic       rx_data_valid;
  logic [7:0] rx_byte;
  logic       msg_valid;
  logic       msg_error;
  logic [3:0] sim_id;
  logic [7:0] unit_code;
  logic [2:0] color_out;
  logic       busy;

  modport slave (
    input  rx_data_valid, rx_byte,
    output msg_valid, msg_error, sim_id, unit_code, color_out, busy
  );

  modport master (
    output rx_data_valid, rx_byte,
    input  msg_valid, msg_error, sim_id, unit_code, color_out, busy
  );
endinterface

// File: rtl/uart_msg_parser.sv
// uart_msg_parser: parses frames "SI-SIM<d>-<L>-#"<CR> from a UART RX byte stream.
// Pulses msg_valid on a good frame (decoded fields update in the same cycle) and
// msg_error on a malformed or timed-out frame.
// Optional: define UART_PARSER_LED_EN to add led_R/led_G/led_B outputs.
module uart_msg_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic clk,
  input  logic rst_n,
  uart_msg_parser_if.slave bus
`ifdef UART_PARSER_LED_EN
  ,
  output logic led_R,
  output logic led_G,
  output logic led_B
`endif
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_next;
  logic [3:0]       idx, idx_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic             valid_next, error_next;
  logic             cap_digit, cap_letter;
  logic             byte_ok;
  logic [3:0]       shadow_digit;
  logic [7:0]       shadow_letter;

  function automatic logic [2:0] color_of(input logic [7:0] letter);
    case (letter)
      "P":     color_of = 3'b001;
      "W":     color_of = 3'b010;
      "N":     color_of = 3'b100;
      default: color_of = 3'b000;
    endcase
  endfunction

  // Does rx_byte match the template slot at idx
  always_comb begin
    byte_ok = 1'b0;
    case (idx)
      4'd0, 4'd3:        byte_ok = (bus.rx_byte == "S");
      4'd1, 4'd4:        byte_ok = (bus.rx_byte == "I");
      4'd2, 4'd7, 4'd9:  byte_ok = (bus.rx_byte == "-");
      4'd5:              byte_ok = (bus.rx_byte == "M");
      4'd6:              byte_ok = (bus.rx_byte >= "0") && (bus.rx_byte <= "9");
      4'd8:              byte_ok = (bus.rx_byte >= "A") && (bus.rx_byte <= "Z");
      4'd10:             byte_ok = (bus.rx_byte == "#");
      4'd11:             byte_ok = (bus.rx_byte == 8'h0D);
      default:           byte_ok = 1'b0;
    endcase
  end

  // Next-state, index, timer and pulse decisions
  always_comb begin
    state_next = state;
    idx_next   = idx;
    timer_next = timer;
    valid_next = 1'b0;
    error_next = 1'b0;
    cap_digit  = 1'b0;
    cap_letter = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_data_valid && bus.rx_byte == "S") begin
          state_next = RECV;
          idx_next   = 4'd1;
          timer_next = '0;
        end
      end
      RECV: begin
        // A strobe in the timer-expiry cycle wins over the timeout.
        if (bus.rx_data_valid) begin
          timer_next = '0;
          if (byte_ok) begin
            if (idx == 4'd11) begin
              valid_next = 1'b1;
              state_next = IDLE;
              idx_next   = '0;
            end else begin
              idx_next   = idx + 4'd1;
              cap_digit  = (idx == 4'd6);
              cap_letter = (idx == 4'd8);
            end
          end else begin
            error_next = 1'b1;
            if (bus.rx_byte == "S") begin
              idx_next = 4'd1;
            end else begin
              state_next = IDLE;
              idx_next   = '0;
            end
          end
        end else if (timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          error_next = 1'b1;
          state_next = IDLE;
          idx_next   = '0;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        timer_next = '0;
      end
    endcase
  end

  // State, index, timer and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      timer         <= '0;
      shadow_digit  <= '0;
      shadow_letter <= '0;
      bus.msg_valid <= 1'b0;
      bus.msg_error <= 1'b0;
      bus.sim_id    <= '0;
      bus.unit_code <= '0;
      bus.color_out <= '0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      timer         <= timer_next;
      bus.msg_valid <= valid_next;
      bus.msg_error <= error_next;
      if (cap_digit)  shadow_digit  <= bus.rx_byte[3:0];
      if (cap_letter) shadow_letter <= bus.rx_byte;
      if (valid_next) begin
        bus.sim_id    <= shadow_digit;
        bus.unit_code <= shadow_letter;
        bus.color_out <= color_of(shadow_letter);
      end
    end
  end

  assign bus.busy = (state == RECV);

`ifdef UART_PARSER_LED_EN
  // LEDs follow the colour of each accepted frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_R <= 1'b0;
      led_G <= 1'b0;
      led_B <= 1'b0;
    end else if (valid_next) begin
      led_R <= color_of(shadow_letter)[0];
      led_G <= color_of(shadow_letter)[2];
      led_B <= color_of(shadow_letter)[1];
    end
  end
`endif

endmodule

// File: tb/tb_uart_msg_parser.sv
// Scoreboard bench for uart_msg_parser: stimulus pushes expected pulses into a
// queue, a monitor pops and compares on every msg_valid/msg_error pulse.
module tb_uart_msg_parser;
  logic clk = 1'b0;
  logic rst_n;

  uart_msg_parser_if bus();

`ifdef UART_PARSER_LED_EN
  logic led_R, led_G, led_B;
`endif

  uart_msg_parser #(.TIMEOUT_CYCLES(100), .CNT_W(26)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UART_PARSER_LED_EN
    ,
    .led_R (led_R),
    .led_G (led_G),
    .led_B (led_B)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_error;
    logic [3:0] sim;
    logic [7:0] unit;
    logic [2:0] color;
  } exp_t;

  exp_t sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Last accepted frame fields, as expected by the bench
  logic [3:0] last_sim   = '0;
  logic [7:0] last_unit  = '0;
  logic [2:0] last_color = '0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_valid(input logic [3:0] s, input logic [7:0] u, input logic [2:0] c);
    exp_t e;
    e.is_error = 1'b0; e.sim = s; e.unit = u; e.color = c;
    sb.push_back(e);
    last_sim = s; last_unit = u; last_color = c;
  endtask

  task automatic push_error();
    exp_t e;
    e.is_error = 1'b1; e.sim = last_sim; e.unit = last_unit; e.color = last_color;
    sb.push_back(e);
  endtask

  // gap = number of idle cycles after the strobe (0 = next byte follows immediately)
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    @(negedge clk);
    bus.rx_data_valid = 1'b1;
    bus.rx_byte       = b;
    if (gap > 0) begin
      @(negedge clk);
      bus.rx_data_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic send_str(input string s, input int unsigned gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_sim"},   bus.sim_id,    0);
    chk({tag, "_unit"},  bus.unit_code, 0);
    chk({tag, "_color"}, bus.color_out, 0);
    chk({tag, "_busy"},  bus.busy,      0);
    chk({tag, "_pulse"}, {bus.msg_valid, bus.msg_error}, 0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.msg_valid && bus.msg_error) begin
      miscompares++;
      $display("FAIL both_pulses: msg_valid and msg_error high together");
    end
    if (rst_n && (bus.msg_valid || bus.msg_error)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b expected none",
                 bus.msg_valid, bus.msg_error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {bus.msg_valid, bus.msg_error}, e.is_error ? 2'b01 : 2'b10);
        chk("sim_id",     bus.sim_id,    e.sim);
        chk("unit_code",  bus.unit_code, e.unit);
        chk("color_out",  bus.color_out, e.color);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.rx_data_valid = 1'b0;
    bus.rx_byte = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Single frame, spaced bytes
    push_valid(4'd1, 8'h50, 3'b001);
    send_str("SI-SIM1-P-", 10);
    chk("busy_mid_frame", bus.busy, 1);
    send_str("#", 10);
    send_byte(8'h0D, 10);

    // Back-to-back frames with no gaps at all
    push_valid(4'd3, 8'h57, 3'b010);
    push_valid(4'd2, 8'h4E, 3'b100);
    send_str("SI-SIM3-W-#", 0);
    send_byte(8'h0D, 0);
    send_str("SI-SIM2-N-#", 0);
    send_byte(8'h0D, 3);

    // Mismatch on 'X'
    push_error();
    send_str("SI-SIX", 2);
    repeat (3) @(negedge clk);
    chk("busy_after_mismatch", bus.busy, 0);

    // 'S' at the mismatch slot resynchronises
    push_error();
    push_valid(4'd4, 8'h50, 3'b001);
    send_str("SI-SI", 2);
    send_str("S", 2);
    send_str("I-SIM4-P-#", 2);
    send_byte(8'h0D, 3);

    // Timeout after 100 idle cycles
    push_error();
    send_str("SI-", 3);
    send_byte("S", 1);
    repeat (95) @(negedge clk);
    chk("timeout_not_early", sb.size(), 1);
    chk("busy_before_timeout", bus.busy, 1);
    repeat (10) @(negedge clk);
    chk("timeout_fired", sb.size(), 0);
    chk("busy_after_timeout", bus.busy, 0);

    // Reset mid-frame: no error, outputs cleared, next frame accepted
    send_str("SI-SIM5", 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    last_sim = '0; last_unit = '0; last_color = '0;
    push_valid(4'd6, 8'h4E, 3'b100);
    send_str("SI-SIM6-N-#", 1);
    send_byte(8'h0D, 5);
    chk("final_sim",   bus.sim_id,    6);
    chk("final_color", bus.color_out, 3'b100);
    chk("final_busy",  bus.busy,      0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
